priority_scan_encoder: RTL and testbench

- Parametrised, sequential successor to our wide one-hot/priority encoders.
- Captures an N-bit request vector and emits the index of every set bit, one index per beat, over a valid/ready stream.
- Scan order is selectable per load: highest index first or lowest index first.
- An all-zero vector produces a single explicit "none" beat instead of an undefined output.
- Sits between wide request/flag vectors (interrupt, hit, match lines) and downstream serial consumers.

---
 rtl/priority_scan_encoder.sv | 143 ++++++++++++++
 tb/tb_priority_scan_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_scan_encoder.sv
// Sequential priority encoder: captures an N-bit request vector and streams
// the index of every set bit, one per beat, highest- or lowest-first.
module priority_scan_encoder #(
    parameter int unsigned N  = 1024,
    parameter int unsigned W  = 10,
    parameter int unsigned CW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_vec,
    input  logic          in_dir,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_idx,
    output logic          out_last,
    output logic          out_none,
    output logic [CW-1:0] out_seq,
    output logic          busy
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   pending, pending_nxt;
    logic           dir_q, dir_nxt;
    logic           in_ready_nxt, out_valid_nxt, out_last_nxt, out_none_nxt, busy_nxt;
    logic [W-1:0]   out_idx_nxt;
    logic [CW-1:0]  out_seq_nxt;

    // Shared encoder operand: the fresh vector while idle, the remainder while scanning
    logic [N-1:0]   enc_src_c;
    logic           enc_dir_c;
    logic [W-1:0]   enc_idx_c;
    logic [N-1:0]   enc_rest_c;

    // Highest (hi=1) or lowest (hi=0) set index; 0 when nothing is set
    function automatic logic [W-1:0] encode(input logic [N-1:0] v, input logic hi);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (hi) begin
                if (v[i]) r = W'(i);
            end else begin
                if (v[int'(N) - 1 - i]) r = W'(int'(N) - 1 - i);
            end
        end
        return r;
    endfunction

    // Select encoder operand and compute the vector with the chosen bit removed
    always_comb begin
        enc_src_c  = (state == IDLE) ? in_vec : pending;
        enc_dir_c  = (state == IDLE) ? in_dir : dir_q;
        enc_idx_c  = encode(enc_src_c, enc_dir_c);
        enc_rest_c = enc_src_c & ~(N'(1) << enc_idx_c);
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        pending_nxt   = pending;
        dir_nxt       = dir_q;
        in_ready_nxt  = in_ready;
        out_valid_nxt = out_valid;
        out_idx_nxt   = out_idx;
        out_last_nxt  = out_last;
        out_none_nxt  = out_none;
        out_seq_nxt   = out_seq;
        busy_nxt      = busy;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_nxt     = SCAN;
                    dir_nxt       = in_dir;
                    in_ready_nxt  = 1'b0;
                    busy_nxt      = 1'b1;
                    out_valid_nxt = 1'b1;
                    out_seq_nxt   = '0;
                    if (|in_vec) begin
                        out_idx_nxt  = enc_idx_c;
                        pending_nxt  = enc_rest_c;
                        out_last_nxt = (enc_rest_c == '0);
                        out_none_nxt = 1'b0;
                    end else begin
                        out_idx_nxt  = '0;
                        pending_nxt  = '0;
                        out_last_nxt = 1'b1;
                        out_none_nxt = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        state_nxt     = IDLE;
                        in_ready_nxt  = 1'b1;
                        busy_nxt      = 1'b0;
                        out_valid_nxt = 1'b0;
                        out_last_nxt  = 1'b0;
                        out_none_nxt  = 1'b0;
                    end else begin
                        out_idx_nxt  = enc_idx_c;
                        pending_nxt  = enc_rest_c;
                        out_last_nxt = (enc_rest_c == '0);
                        out_seq_nxt  = out_seq + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            dir_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_none  <= 1'b0;
            out_seq   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            dir_q     <= dir_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            out_idx   <= out_idx_nxt;
            out_last  <= out_last_nxt;
            out_none  <= out_none_nxt;
            out_seq   <= out_seq_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Scoreboard bench for priority_scan_encoder.
module tb_priority_scan_encoder;

    localparam int unsigned N  = 1024;
    localparam int unsigned W  = 10;
    localparam int unsigned CW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_vec;
    logic          in_dir;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_idx;
    logic          out_last;
    logic          out_none;
    logic [CW-1:0] out_seq;
    logic          busy;

    typedef struct {
        int unsigned idx;
        bit          last;
        bit          none;
        int unsigned seq;
    } beat_t;

    beat_t q[$];
    int    total = 0;
    int    bad   = 0;

    // Stall snapshot and post-final-beat tracking for the monitor
    bit            stall_prev = 1'b0;
    bit            after_last = 1'b0;
    logic [W-1:0]  snap_idx;
    logic          snap_last, snap_none;
    logic [CW-1:0] snap_seq;

    priority_scan_encoder #(.N(N), .W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_none  (out_none),
        .out_seq   (out_seq),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: push every expected beat for a vector and scan order
    task automatic push_expected(input logic [N-1:0] v, input bit d);
        int k, s;
        beat_t b;
        k = 0;
        for (int i = 0; i < int'(N); i++) if (v[i]) k++;
        if (k == 0) begin
            b.idx = 0; b.last = 1'b1; b.none = 1'b1; b.seq = 0;
            q.push_back(b);
            return;
        end
        s = 0;
        for (int j = 0; j < int'(N); j++) begin
            int i;
            i = d ? (int'(N) - 1 - j) : j;
            if (v[i]) begin
                b.idx = i; b.none = 1'b0; b.seq = s; b.last = (s == k - 1);
                q.push_back(b);
                s++;
            end
        end
    endtask

    // Monitor: compare each accepted beat and hold-stability under backpressure
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            after_last = 1'b0;
        end else begin
            if (after_last) begin
                check("ready_after_last", 32'(in_ready), 32'd1);
                check("valid_after_last", 32'(out_valid), 32'd0);
                after_last = 1'b0;
            end
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_idx",   32'(out_idx),   32'(snap_idx));
                check("stall_last",  32'(out_last),  32'(snap_last));
                check("stall_none",  32'(out_none),  32'(snap_none));
                check("stall_seq",   32'(out_seq),   32'(snap_seq));
            end
            stall_prev = 1'b0;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 32'(out_idx), 32'hFFFF_FFFF);
                end else begin
                    beat_t b;
                    b = q.pop_front();
                    check("idx",  32'(out_idx),  b.idx);
                    check("last", 32'(out_last), 32'(b.last));
                    check("none", 32'(out_none), 32'(b.none));
                    check("seq",  32'(out_seq),  b.seq);
                    check("busy", 32'(busy),     32'd1);
                    if (out_last === 1'b1) after_last = 1'b1;
                end
            end else if (out_valid === 1'b1) begin
                stall_prev = 1'b1;
                snap_idx   = out_idx;
                snap_last  = out_last;
                snap_none  = out_none;
                snap_seq   = out_seq;
            end
        end
    end

    // Load a vector; returns one cycle after acceptance with in_valid left at keep_valid
    task automatic load(input logic [N-1:0] v, input logic d, input logic keep_valid);
        int t;
        t = 0;
        while (in_ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        check("load_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_vec   = v;
        in_dir   = d;
        push_expected(v, d);
        @(posedge clk); #1;
        in_valid = keep_valid;
        in_vec   = '0;
        in_dir   = ~d;
        check("first_valid", 32'(out_valid), 32'd1);
        check("load_busy",   32'(busy),      32'd1);
        check("load_nready", 32'(in_ready),  32'd0);
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (q.size() != 0 && t < budget) begin
            @(posedge clk); #1; t++;
        end
        check("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [N-1:0] v;
        logic [4:0]   pat;

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_vec    = {N{1'b1}};
        in_dir    = 1'b1;
        out_ready = 1'b1;

        // Reset held two cycles with a pending load request
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_in_ready",  32'(in_ready),  32'd1);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_busy",      32'(busy),      32'd0);
            check("rst_idx",       32'(out_idx),   32'd0);
            check("rst_last",      32'(out_last),  32'd0);
            check("rst_none",      32'(out_none),  32'd0);
            check("rst_seq",       32'(out_seq),   32'd0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_ready", 32'(in_ready),  32'd1);

        // Three bits, highest first, no backpressure
        v = '0; v[3] = 1'b1; v[700] = 1'b1; v[1023] = 1'b1;
        load(v, 1'b1, 1'b0);
        drain(20);
        @(posedge clk); #1;

        // Same vector lowest first with stalls
        load(v, 1'b0, 1'b0);
        pat = 5'b11001;
        for (int i = 0; i < 5; i++) begin
            out_ready = pat[i];
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain(20);
        @(posedge clk); #1;

        // All-zero vector: single none beat
        load('0, 1'b1, 1'b0);
        drain(10);
        @(posedge clk); #1;

        // All ones, lowest first, in_valid held high throughout the scan
        load({N{1'b1}}, 1'b0, 1'b1);
        in_vec = 'h55;
        drain(N + 20);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("post_full_idle", 32'(out_valid), 32'd0);

        // Reset mid-scan after the first handshake
        v = '0; v[5] = 1'b1; v[9] = 1'b1; v[12] = 1'b1;
        load(v, 1'b0, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready),  32'd1);
        check("midrst_busy",  32'(busy),      32'd0);
        out_ready = 1'b1;

        // Single-bit vector after the reset
        v = '0; v[2] = 1'b1;
        load(v, 1'b1, 1'b0);
        drain(10);
        @(posedge clk); #1;
        check("final_idle", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
